// File: rtl/conv2d_pkg.sv
// rtl/conv2d_pkg.sv - register map, CTRL bit positions, field masks and run-state encoding
package conv2d_pkg;
    localparam int REG_CTRL   = 0;
    localparam int REG_CYCLES = 1;
    localparam int REG_SHAPE  = 2;
    localparam int REG_CHAN   = 3;
    localparam int REG_KW0    = 4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_DONE     = 1;
    localparam int CTRL_MODE_LO  = 2;
    localparam int CTRL_MODE_HI  = 4;
    localparam int CTRL_LAYER_LO = 5;
    localparam int CTRL_LAYER_HI = 8;
    localparam int CTRL_CFG_ERR  = 9;

    localparam logic [31:0] SHAPE_MASK = 32'h001F_FFFF;
    localparam logic [31:0] CHAN_MASK  = 32'h000F_FFFF;
    localparam logic [31:0] KW_MASK    = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } run_state_e;
endpackage

// File: rtl/conv2d_ctrl_regfile.sv
// rtl/conv2d_ctrl_regfile.sv - host/accelerator control register file with run-state FSM,
// saturating run-cycle counter and completion interrupt
module conv2d_ctrl_regfile
    import conv2d_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int KW_FIRST = 4,
    parameter int KW_LAST  = 12
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [$clog2(NUM_REGS)-1:0] i_ctrl_addr,
    output logic [31:0]                 o_ctrl_data,
    input  logic                        i_ctrl_we,
    input  logic [31:0]                 i_ctrl_data,
    input  logic [$clog2(NUM_REGS)-1:0] i_host_addr,
    input  logic                        i_host_we,
    input  logic [31:0]                 i_host_wdata,
    input  logic                        i_host_re,
    output logic [31:0]                 o_host_rdata,
    output logic                        o_host_rvalid,
    output logic                        o_busy,
    output logic                        o_irq
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int KW_N   = KW_LAST - KW_FIRST + 1;
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(REG_CTRL);
    localparam logic [ADDR_W-1:0] A_SHAPE    = ADDR_W'(REG_SHAPE);
    localparam logic [ADDR_W-1:0] A_CHAN     = ADDR_W'(REG_CHAN);
    localparam logic [ADDR_W-1:0] A_KW_FIRST = ADDR_W'(KW_FIRST);
    localparam logic [ADDR_W-1:0] A_KW_LAST  = ADDR_W'(KW_LAST);

    run_state_e        state_q;
    logic              start_q, done_q, cfg_err_q, busy_q, irq_q, host_rvalid_q;
    logic [2:0]        mode_q;
    logic [3:0]        layer_q;
    logic [31:0]       cycles_q, cycles_d, shape_q, chan_q;
    logic [31:0]       ctrl_rdata_q, host_rdata_q;
    logic [31:0]       kw_q [KW_N];
    logic [31:0]       rd_view [NUM_REGS];
    logic              host_in_kw, host_cfg_wr, host_ctrl_wr, accel_ctrl_wr;
    logic [ADDR_W-1:0] kw_idx;

    assign cycles_d      = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    assign host_in_kw    = (i_host_addr >= A_KW_FIRST) && (i_host_addr <= A_KW_LAST);
    assign kw_idx        = i_host_addr - A_KW_FIRST;
    assign host_ctrl_wr  = i_host_we && (i_host_addr == A_CTRL);
    assign host_cfg_wr   = i_host_we && ((i_host_addr == A_CTRL) || (i_host_addr == A_SHAPE) ||
                                         (i_host_addr == A_CHAN) || host_in_kw);
    assign accel_ctrl_wr = i_ctrl_we && (i_ctrl_addr == A_CTRL);

    // Unmapped and reserved indices stay zero so both read ports return 0 there.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) rd_view[i] = '0;
        rd_view[REG_CTRL]   = {22'd0, cfg_err_q, layer_q, mode_q, done_q, start_q};
        rd_view[REG_CYCLES] = cycles_q;
        rd_view[REG_SHAPE]  = shape_q;
        rd_view[REG_CHAN]   = chan_q;
        for (int i = 0; i < KW_N; i++) rd_view[KW_FIRST + i] = kw_q[i];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            irq_q         <= 1'b0;
            host_rvalid_q <= 1'b0;
            mode_q        <= '0;
            layer_q       <= '0;
            cycles_q      <= '0;
            shape_q       <= '0;
            chan_q        <= '0;
            ctrl_rdata_q  <= '0;
            host_rdata_q  <= '0;
            for (int i = 0; i < KW_N; i++) kw_q[i] <= '0;
        end else begin
            irq_q         <= 1'b0;
            ctrl_rdata_q  <= rd_view[i_ctrl_addr];
            host_rvalid_q <= i_host_re;
            if (i_host_re) host_rdata_q <= rd_view[i_host_addr];

            case (state_q)
                ST_RUN: begin
                    cycles_q <= cycles_d;
                    if (host_cfg_wr) cfg_err_q <= 1'b1;
                    if (accel_ctrl_wr) begin
                        layer_q <= i_ctrl_data[CTRL_LAYER_HI:CTRL_LAYER_LO];
                        if (i_ctrl_data[CTRL_DONE]) begin
                            start_q <= 1'b0;
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    if (host_ctrl_wr) begin
                        mode_q <= i_host_wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                        if (i_host_wdata[CTRL_START]) begin
                            start_q  <= 1'b1;
                            done_q   <= 1'b0;
                            cycles_q <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_RUN;
                        end else begin
                            // Acknowledging done (wdata[1]=0) is what returns DONE to IDLE.
                            if (!i_host_wdata[CTRL_DONE]) begin
                                done_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                            if (!i_host_wdata[CTRL_CFG_ERR]) cfg_err_q <= 1'b0;
                        end
                    end
                    if (i_host_we && (i_host_addr == A_SHAPE)) shape_q <= i_host_wdata & SHAPE_MASK;
                    if (i_host_we && (i_host_addr == A_CHAN))  chan_q  <= i_host_wdata & CHAN_MASK;
                    if (i_host_we && host_in_kw)               kw_q[kw_idx] <= i_host_wdata & KW_MASK;
                end
            endcase
        end
    end

    assign o_ctrl_data   = ctrl_rdata_q;
    assign o_host_rdata  = host_rdata_q;
    assign o_host_rvalid = host_rvalid_q;
    assign o_busy        = busy_q;
    assign o_irq         = irq_q;
endmodule

// File: tb/tb_conv2d_ctrl_regfile.sv
// tb/tb_conv2d_ctrl_regfile.sv - scoreboard bench for conv2d_ctrl_regfile
module tb_conv2d_ctrl_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ctrl_addr = '0;
    logic        ctrl_we = 1'b0;
    logic [31:0] ctrl_wdata = '0;
    logic [31:0] ctrl_rdata;
    logic [3:0]  host_addr = '0;
    logic        host_we = 1'b0;
    logic [31:0] host_wdata = '0;
    logic        host_re = 1'b0;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        busy;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t host_q[$];
    exp_t ctrl_q[$];
    logic ctrl_req = 1'b0;
    logic ctrl_due = 1'b0;
    int   errors = 0;
    int   checks = 0;

    conv2d_ctrl_regfile dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ctrl_addr  (ctrl_addr),
        .o_ctrl_data  (ctrl_rdata),
        .i_ctrl_we    (ctrl_we),
        .i_ctrl_data  (ctrl_wdata),
        .i_host_addr  (host_addr),
        .i_host_we    (host_we),
        .i_host_wdata (host_wdata),
        .i_host_re    (host_re),
        .o_host_rdata (host_rdata),
        .o_host_rvalid(host_rvalid),
        .o_busy       (busy),
        .o_irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) ctrl_due <= ctrl_req;

    // Pops one expectation per read result produced by either port.
    always @(negedge clk) begin
        exp_t e;
        if (host_rvalid) begin
            if (host_q.size() == 0) check("host_rvalid_spurious", {31'd0, host_rvalid}, 32'd0);
            else begin
                e = host_q.pop_front();
                check(e.tag, host_rdata, e.exp);
            end
        end
        if (ctrl_due && ctrl_q.size() != 0) begin
            e = ctrl_q.pop_front();
            check(e.tag, ctrl_rdata, e.exp);
        end
    end

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        exp_t e;
        e.tag = tag; e.exp = exp;
        host_q.push_back(e);
        host_re = 1'b1; host_addr = a;
        @(negedge clk);
        host_re = 1'b0;
    endtask

    task automatic ctrl_write(input logic [3:0] a, input logic [31:0] d);
        ctrl_we = 1'b1; ctrl_addr = a; ctrl_wdata = d;
        @(negedge clk);
        ctrl_we = 1'b0;
    endtask

    task automatic ctrl_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        exp_t e;
        e.tag = tag; e.exp = exp;
        ctrl_q.push_back(e);
        ctrl_req = 1'b1; ctrl_addr = a;
        @(negedge clk);
        ctrl_req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b0;

        // configuration with out-of-field bits that must be masked off
        host_write(4'd2, 32'hFFEB_0606);
        host_write(4'd3, 32'hFFF0_4003);
        host_write(4'd4, 32'h1234_0100);
        host_write(4'd12, 32'hFFFF_8001);
        host_write(4'd13, 32'hDEAD_BEEF);
        host_write(4'd1, 32'h1234_5678);
        ctrl_read(4'd2, 32'h000B_0606, "ctrl_shape");
        ctrl_read(4'd3, 32'h0000_4003, "ctrl_chan");
        ctrl_read(4'd4, 32'h0000_0100, "ctrl_kw0");
        ctrl_read(4'd12, 32'h0000_8001, "ctrl_kw_last");
        ctrl_read(4'd13, 32'h0000_0000, "ctrl_reserved");
        host_read(4'd1, 32'h0, "cycles_readonly");
        host_read(4'd13, 32'h0, "host_reserved");

        // run of 20 cycles ended by accelerator done write
        host_write(4'd0, 32'h5);
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (19) begin
            check("irq_quiet_in_run", 32'(irq), 32'd0);
            @(negedge clk);
        end
        ctrl_write(4'd0, 32'h2);
        check("irq_on_done", 32'(irq), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("irq_one_cycle", 32'(irq), 32'd0);
        host_read(4'd0, 32'h6, "ctrl_after_done");
        host_read(4'd1, 32'd20, "cycles_run20");

        // host config locked during RUN
        host_write(4'd0, 32'h5);
        check("busy_restart", 32'(busy), 32'd1);
        host_write(4'd2, 32'h0);
        host_read(4'd2, 32'h000B_0606, "lock_shape");
        host_read(4'd0, 32'h205, "lock_cfg_err");
        ctrl_write(4'd0, 32'h62);
        check("irq_second_run", 32'(irq), 32'd1);
        host_read(4'd0, 32'h266, "ctrl_layer_done");
        host_write(4'd0, 32'h0);
        host_read(4'd0, 32'h60, "done_ack_clears");
        check("fsm_idle_after_ack", 32'(dut.state_q), 32'd0);

        // same-cycle host config write and accelerator done
        host_write(4'd0, 32'h1);
        host_read(4'd1, 32'h0, "cycles_cleared_on_start");
        host_we = 1'b1; host_addr = 4'd3; host_wdata = 32'hFFFF_FFFF;
        ctrl_we = 1'b1; ctrl_addr = 4'd0; ctrl_wdata = 32'h2;
        @(negedge clk);
        host_we = 1'b0; ctrl_we = 1'b0;
        check("irq_collision", 32'(irq), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("irq_single_collision", 32'(irq), 32'd0);
        end
        host_read(4'd3, 32'h0000_4003, "collision_chan_kept");
        host_read(4'd0, 32'h202, "collision_ctrl");
        host_write(4'd0, 32'h0);

        // accelerator writes ignored outside RUN
        ctrl_write(4'd0, 32'h2);
        ctrl_write(4'd2, 32'h0);
        host_read(4'd0, 32'h0, "idle_accel_ctrl_ignored");
        host_read(4'd2, 32'h000B_0606, "idle_accel_shape_ignored");
        check("irq_idle_accel", 32'(irq), 32'd0);

        // cycle counter saturation
        host_write(4'd0, 32'h1);
        dut.cycles_q = 32'hFFFF_FFFE;
        repeat (5) @(negedge clk);
        host_read(4'd1, 32'hFFFF_FFFF, "cycles_saturate_host");
        ctrl_read(4'd1, 32'hFFFF_FFFF, "cycles_saturate_ctrl");

        // asynchronous reset in the middle of RUN
        ctrl_addr = 4'd0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ctrl_data", ctrl_rdata, 32'd0);
        check("rst_host_rdata", host_rdata, 32'd0);
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) host_read(4'(a), 32'h0, $sformatf("rst_reg%0d", a));
        check("rst_no_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        check("host_sb_drained", 32'(host_q.size()), 32'd0);
        check("ctrl_sb_drained", 32'(ctrl_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv2d_ctrl_regfile.md
Name: conv2d_ctrl_regfile

Overview:
Host-facing control/status register file for top_conv2d. It responds to the accelerator's ctrl port (o_ctrl_addr/i_ctrl_data/o_ctrl_we/o_ctrl_data) as a 16x32 memory with 1-cycle registered read latency. It exposes a simple host register port for configuration, and owns the start/done run-state FSM, a run-cycle counter and the completion interrupt.

Parameters:
NUM_REGS, 16, register count; address width is clog2(NUM_REGS)=4.
KW_FIRST, 4, first kernel-weight register index.
KW_LAST, 12, last kernel-weight register index.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_ctrl_addr  in  4  accelerator read/write address.
o_ctrl_data  out  32  accelerator read data; registered, valid 1 cycle after address.
i_ctrl_we  in  1  accelerator write enable.
i_ctrl_data  in  32  accelerator write data.
i_host_addr  in  4  host address.
i_host_we  in  1  host write strobe.
i_host_wdata  in  32  host write data.
i_host_re  in  1  host read strobe.
o_host_rdata  out  32  host read data; registered.
o_host_rvalid  out  1  one-cycle pulse, 1 cycle after i_host_re.
o_busy  out  1  high in RUN.
o_irq  out  1  one-cycle pulse on RUN->DONE.

Behaviour:
- Reset (async, i_rst=1): all registers 0, FSM=IDLE, and every output 0.
- Reg 0 (CTRL): [0] start, [1] done, [2] conv, [3] bnrelu, [4] maxpool, [8:5] cur_layer, [9] cfg_err (sticky), [31:10] read as 0.
- Reg 1 (CYCLES): read-only. Cleared on the start transition. Increments once per cycle in RUN and saturates at 32'hFFFFFFFF.
- Reg 2 (SHAPE): [7:0] width, [15:8] height, [17:16] kernel, [18] padding, [20:19] stride. Other bits read 0.
- Reg 3 (CHAN): [9:0] in-channel, [19:10] out-channel. Other bits read 0.
- Regs 4..12 (KW): weights in [15:0] as signed Q8.8. Bits [31:16] read 0.
- Regs 13..15: reserved. Writes are dropped and reads return 0.
- Reads: o_ctrl_data <= reg[i_ctrl_addr] every cycle, with no enable. o_host_rdata <= reg[i_host_addr] when i_host_re. Both ports read concurrently without conflict.
- FSM IDLE:
  - A host write to reg 0 with wdata[0]=1 loads [4:2], clears [1], sets [0], clears CYCLES and goes to RUN.
  - A host write with wdata[0]=0 updates [4:2]. If wdata[1]=0 it also clears done; if wdata[9]=0 it clears cfg_err.
- FSM RUN (o_busy=1):
  - Host writes to regs 0, 2..12 are dropped and set cfg_err=1.
  - An accelerator write to reg 0 updates cur_layer [8:5] from i_ctrl_data[8:5].
  - If that write has i_ctrl_data[1]=1, then start<=0, done<=1, o_irq pulses next cycle, and the FSM goes to DONE.
  - Accelerator writes to any other address are ignored.
- FSM DONE: o_busy=0.
  - A host write to reg 0 with wdata[0]=1 restarts, exactly as from IDLE.
  - A host write with wdata[0]=0 and wdata[1]=0 clears done and goes to IDLE.
  - Other regs are writable.
- Writes in IDLE/DONE: host writes to regs 2..12 take effect on the next edge, masked to their defined fields. Accelerator writes are ignored.
- Simultaneous events in the same cycle:
  - In RUN: an accelerator done write takes effect, and a host write in that cycle is dropped with cfg_err set.
  - Same-cycle read and write of the same address returns the old value (read-before-write).
- Reset mid-RUN: immediate return to IDLE with all registers 0. No irq is generated.

Decomposition:
- Package conv2d_pkg holds:
  - register index localparams (REG_CTRL=0, REG_CYCLES=1, REG_SHAPE=2, REG_CHAN=3, REG_KW0=4);
  - CTRL bit-position localparams;
  - field write masks;
  - FSM state encoding (IDLE, RUN, DONE; 2 bits).
- There are no sub-modules; the block is a single flat module. The FSM and register array are small enough that a split adds nothing.

Test Plan:
1. Reset: assert i_rst mid-cycle. All outputs go to 0 asynchronously, and reading regs 0..15 returns 0.
2. Config: host writes reg2=0x000B0606, reg3=0x00004003 and reg4=0x1234_0100. After this, ctrl reads at addr 2, 3, 4 return 0x000B0606, 0x00004003 and 0x00000100, each 1 cycle after the address.
3. Run: host writes reg0=0x5. o_busy=1 on the next cycle. The accelerator writes reg0 with data 0x2 after 20 cycles. Then reg0 reads 0x6, o_irq is high for exactly 1 cycle, o_busy=0, and reg1=20.
4. Lock: during RUN, host writes reg2=0. reg2 is unchanged and reg0[9]=1. Host then writes reg0=0x0 in DONE: done=0, cfg_err=0, FSM=IDLE.
5. Collision: in the same cycle, the host writes reg3 and the accelerator writes reg0 with done=1. Done is taken, reg3 is unchanged, cfg_err=1, and exactly one irq occurs.
6. Saturation and idle writes: force CYCLES near 0xFFFFFFFE (hierarchical deposit) and run 5 cycles. CYCLES holds at 0xFFFFFFFF. An accelerator write in IDLE to reg0 with data 0x2 leaves reg0 unchanged.
